// File: rtl/dmem_ctrl_pkg.sv
// Shared codes, state encoding and store-lane helpers for dmem_ctrl.
// Optional feature macro: DMEM_ERR_CNT_EN (error counter output).
package dmem_ctrl_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_HW = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  localparam int LANE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPT,
    S_RESP
  } state_t;

  function automatic logic [3:0] st_be(
    input logic [2:0] mode,
    input logic [1:0] lo
  );
    case (mode)
      MEM_B:   st_be = BE_B0 << lo;
      MEM_HW:  st_be = lo[1] ? BE_HI : BE_LO;
      MEM_W:   st_be = BE_ALL;
      default: st_be = BE_NONE;
    endcase
  endfunction

  function automatic logic [31:0] st_data(
    input logic [2:0]  mode,
    input logic [31:0] wd
  );
    case (mode)
      MEM_B:   st_data = {4{wd[LANE_W-1:0]}};
      MEM_HW:  st_data = {2{wd[HALF_W-1:0]}};
      default: st_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake plus RAM-side bus of dmem_ctrl.
// Optional feature macro: DMEM_ERR_CNT_EN (not used here).
interface dmem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mode;
  logic              unsigned_ld;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rdata;
  logic              err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, mem_read, mem_write,
    input  mode, unsigned_ld, addr, wdata,
    input  rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rdata, err,
    output ram_addr, ram_re, ram_we,
    output ram_be, ram_wdata
  );

  modport master (
    output req_valid, mem_read, mem_write,
    output mode, unsigned_ld, addr, wdata,
    output rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rdata, err,
    input  ram_addr, ram_re, ram_we,
    input  ram_be, ram_wdata
  );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load lane select with sign/zero extension.
// Optional feature macro: DMEM_ERR_CNT_EN (not used here).
module dmem_load_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_mode,
  input  logic        i_uns,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sb;
  logic        w_sh;

  always_comb begin
    w_byte = i_data[{i_lane, 3'b000} +: LANE_W];
    w_half = i_lane[1] ? i_data[31:16]
                       : i_data[15:0];
    w_sb   = ~i_uns & w_byte[7];
    w_sh   = ~i_uns & w_half[15];
    case (i_mode)
      MEM_B:   o_data = {{24{w_sb}}, w_byte};
      MEM_HW:  o_data = {{16{w_sh}}, w_half};
      default: o_data = i_data;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Load/store responder driving a synchronous-read byte-enable RAM.
// Optional feature macro: DMEM_ERR_CNT_EN adds err_count[15:0].
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst,
  dmem_ctrl_if.slave bus
`ifdef DMEM_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);
  state_t      r_state;
  logic [1:0]  r_lane;
  logic [2:0]  r_mode;
  logic        r_uns;
  logic        r_load;

  logic        w_rd;
  logic        w_wr;
  logic        w_nop;
  logic        w_mode_ok;
  logic        w_mis;
  logic        w_oor;
  logic        w_err;
  logic        w_acc;
  logic [31:0] w_fmt;

  assign w_rd  = bus.mem_read;
  assign w_wr  = bus.mem_write;
  assign w_nop = ~w_rd & ~w_wr;
  assign w_mode_ok = (bus.mode == MEM_B)
                   | (bus.mode == MEM_HW)
                   | (bus.mode == MEM_W);
  assign w_mis = ((bus.mode == MEM_HW)
                  & bus.addr[0])
               | ((bus.mode == MEM_W)
                  & (|bus.addr[1:0]));
  assign w_oor = |bus.addr[31:ADDR_W+2];
  // nops touch no RAM, so only real accesses are checked
  assign w_err = (w_rd & w_wr)
               | (~w_nop
                  & (~w_mode_ok | w_mis | w_oor));
  assign w_acc = (r_state == S_IDLE)
               & bus.req_valid;

  dmem_load_fmt u_fmt (
    .i_data (bus.ram_rdata),
    .i_lane (r_lane),
    .i_mode (r_mode),
    .i_uns  (r_uns),
    .o_data (w_fmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lane        <= '0;
      r_mode        <= MEM_B;
      r_uns         <= 1'b0;
      r_load        <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.ram_re    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_be    <= BE_NONE;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          bus.req_ready <= 1'b0;
          r_lane        <= bus.addr[1:0];
          r_mode        <= bus.mode;
          r_uns         <= bus.unsigned_ld;
          r_load        <= w_rd;
          bus.err       <= w_err;
          bus.rdata     <= '0;
          if (w_err | w_nop) begin
            r_state       <= S_RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            r_state      <= S_ACCESS;
            bus.ram_addr <= bus.addr[ADDR_W+1:2];
            bus.ram_re   <= w_rd;
            bus.ram_we   <= w_wr;
            if (w_wr) begin
              bus.ram_be <= st_be(bus.mode,
                                  bus.addr[1:0]);
              bus.ram_wdata <= st_data(bus.mode,
                                       bus.wdata);
            end
          end
        end
        S_ACCESS: begin
          bus.ram_re <= 1'b0;
          bus.ram_we <= 1'b0;
          bus.ram_be <= BE_NONE;
          if (r_load) begin
            r_state <= S_CAPT;
          end else begin
            r_state       <= S_RESP;
            bus.rsp_valid <= 1'b1;
          end
        end
        S_CAPT: begin
          bus.rdata     <= w_fmt;
          bus.rsp_valid <= 1'b1;
          r_state       <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.err       <= 1'b0;
          bus.rdata     <= '0;
          bus.req_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (w_acc & w_err
                 & (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a byte-array memory model.
// Optional feature macro: DMEM_ERR_CNT_EN also checks err_count.
module tb_dmem_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dmem_ctrl_if #(.ADDR_W(10)) bif ();

`ifdef DMEM_ERR_CNT_EN
  logic [15:0] err_count;
  int          cnt_m;
`endif

  dmem_ctrl #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
`ifdef DMEM_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [1024];
  logic [7:0]  ref_mem [4096];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      if (bif.ram_we)
        for (int i = 0; i < 4; i++)
          if (bif.ram_be[i])
            ram[bif.ram_addr][8*i +: 8] <= bif.ram_wdata[8*i +: 8];
      if (bif.ram_re) bif.ram_rdata <= ram[bif.ram_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] md);
    case (md)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_err(input logic rd, input logic wr,
                                   input logic [2:0] md,
                                   input logic [31:0] a);
    int n;
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (a >= 32'd4096) return 1'b1;
    n = size_of(md);
    if (n == 0) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] md,
                                           input logic uns,
                                           input logic [31:0] a);
    int n;
    logic [31:0] v;
    logic [31:0] m;
    n = size_of(md);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) begin
      m = (32'd1 << (8 * n)) - 32'd1;
      v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] md,
                                        input logic [31:0] a);
    logic [3:0] b;
    int lo;
    b = 0;
    lo = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + size_of(md)) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] md,
                                         input logic [31:0] w);
    int n;
    logic [31:0] v;
    n = size_of(md);
    v = 0;
    for (int i = 0; i < 4; i++)
      v[8*i +: 8] = w[8*(i % n) +: 8];
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] md, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bif.req_valid   = 1'b1;
    bif.mem_read    = rd;
    bif.mem_write   = wr;
    bif.mode        = md;
    bif.unsigned_ld = uns;
    bif.addr        = a;
    bif.wdata       = wd;
  endtask

  task automatic xact(input logic rd, input logic wr,
                      input logic [2:0] md, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int hold, input logic early);
    logic        e;
    int          lat;
    int          k;
    int          nwe;
    int          nre;
    logic [31:0] erd;
    e   = exp_err(rd, wr, md, a);
    lat = (e || (!rd && !wr)) ? 1 : (wr ? 2 : 3);
    erd = (e || !rd) ? 32'd0 : exp_load(md, uns, a);
    nwe = 0;
    nre = 0;
    chk("req_ready", 32'(bif.req_ready), 1);
    drive(rd, wr, md, uns, a, wd);
    bif.rsp_ready = early;
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
    k = 1;
    forever begin
      if (bif.ram_we) begin
        nwe++;
        chk("ram_be", 32'(bif.ram_be), 32'(exp_be(md, a)));
        chk("ram_wdata", bif.ram_wdata, exp_wd(md, wd));
        chk("ram_addr_w", 32'(bif.ram_addr), 32'(a[11:2]));
      end else begin
        chk("ram_be_idle", 32'(bif.ram_be), 0);
      end
      if (bif.ram_re) begin
        nre++;
        chk("ram_addr_r", 32'(bif.ram_addr), 32'(a[11:2]));
      end
      if (bif.rsp_valid || k >= 8) break;
      chk("busy_rdy", 32'(bif.req_ready), 0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("we_cycles", 32'(nwe), 32'(!e && wr));
    chk("re_cycles", 32'(nre), 32'(!e && rd));
    chk("err", 32'(bif.err), 32'(e));
    chk("rdata", bif.rdata, erd);
    if (!e && wr)
      for (int i = 0; i < size_of(md); i++)
        ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
`ifdef DMEM_ERR_CNT_EN
    if (e && cnt_m < 16'hFFFF) cnt_m++;
`endif
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bif.rsp_valid), 1);
        chk("hold_rdata", bif.rdata, erd);
        chk("hold_err", 32'(bif.err), 32'(e));
        chk("hold_rdy", 32'(bif.req_ready), 0);
      end
      bif.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    chk("idle_valid", 32'(bif.rsp_valid), 0);
    chk("idle_rdy", 32'(bif.req_ready), 1);
`ifdef DMEM_ERR_CNT_EN
    chk("err_count", 32'(err_count), 32'(cnt_m));
`endif
  endtask

  task automatic rst_mid_store();
    chk("rs_rdy", 32'(bif.req_ready), 1);
    drive(1'b0, 1'b1, 3'd2, 1'b0, 32'h40, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("rs_we_on", 32'(bif.ram_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("rs_we_off", 32'(bif.ram_we), 0);
    chk("rs_be", 32'(bif.ram_be), 0);
    chk("rs_wdata", bif.ram_wdata, 0);
    chk("rs_addr", 32'(bif.ram_addr), 0);
    chk("rs_rdy1", 32'(bif.req_ready), 1);
    #1 rst = 1'b0;
`ifdef DMEM_ERR_CNT_EN
    cnt_m = 0;
`endif
    repeat (2) begin
      @(negedge clk);
      chk("rs_no_rsp", 32'(bif.rsp_valid), 0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef DMEM_ERR_CNT_EN
    cnt_m = 0;
`endif
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    bif.req_valid = 1'b0;
    bif.mem_read = 1'b0;
    bif.mem_write = 1'b0;
    bif.mode = 3'd0;
    bif.unsigned_ld = 1'b0;
    bif.addr = '0;
    bif.wdata = '0;
    bif.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", 32'(bif.req_ready), 1);
    chk("rst_valid", 32'(bif.rsp_valid), 0);
    chk("rst_err", 32'(bif.err), 0);
    chk("rst_rdata", bif.rdata, 0);
    chk("rst_re", 32'(bif.ram_re), 0);
    chk("rst_we", 32'(bif.ram_we), 0);
    chk("rst_be", 32'(bif.ram_be), 0);
    chk("rst_addr", 32'(bif.ram_addr), 0);
    chk("rst_wdata", bif.ram_wdata, 0);
`ifdef DMEM_ERR_CNT_EN
    chk("rst_cnt", 32'(err_count), 0);
`endif
    @(negedge clk);
    xact(0, 1, 3'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    xact(1, 0, 3'd0, 0, 32'h13, 32'h0, 0, 0);
    xact(1, 0, 3'd0, 1, 32'h13, 32'h0, 0, 0);
    xact(0, 1, 3'd1, 0, 32'h12, 32'h1234, 0, 0);
    xact(1, 0, 3'd1, 0, 32'h12, 32'h0, 0, 0);
    xact(1, 0, 3'd2, 0, 32'h6, 32'h0, 0, 0);
    xact(1, 0, 3'd2, 0, 32'h10, 32'h0, 5, 0);
    xact(1, 1, 3'd2, 0, 32'h10, 32'h0, 0, 0);
    xact(0, 0, 3'd2, 0, 32'h10, 32'h0, 1, 0);
    xact(1, 0, 3'd3, 0, 32'h10, 32'h0, 0, 0);
    xact(1, 0, 3'd0, 0, 32'h1000, 32'h0, 0, 1);
    rst_mid_store();
    xact(1, 0, 3'd2, 0, 32'h40, 32'h0, 0, 0);
    xact(0, 1, 3'd2, 0, 32'h44, 32'h89ABCDEF, 0, 0);
    xact(1, 0, 3'd1, 0, 32'h46, 32'h0, 0, 0);
    for (int t = 0; t < 300; t++) begin
      int          r;
      logic        rd;
      logic        wr;
      logic [2:0]  md;
      logic [31:0] a;
      int          n;
      r  = $urandom_range(0, 9);
      rd = (r == 1) || (r >= 2 && r <= 5);
      wr = (r == 1) || (r >= 6);
      md = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2))
                                      : 3'($urandom_range(3, 7));
      a  = 32'($urandom_range(0, 255));
      n  = size_of(md);
      if (n > 0 && $urandom_range(0, 9) < 7)
        a = a & ~(32'(n) - 32'd1);
      if ($urandom_range(0, 19) == 0)
        a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
      xact(rd, wr, md, 1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
